// File: rtl/lpc_decoder_ext.sv
// Passive LPC/FWH cycle decoder. It decodes each bus cycle into one record on a valid/ready output.
// State flow: IDLE -> START -> ADDR [-> MSIZE] -> (DATA|TAR1) ... SYNC ... TARE1 -> TARE2 -> emit.
module lpc_decoder_ext #(
  parameter bit          ENABLE_IO  = 1'b1,
  parameter bit          ENABLE_MEM = 1'b1,
  parameter bit          ENABLE_FWH = 1'b1,
  parameter logic [31:0] ADDR_BASE  = 32'h0,
  parameter logic [31:0] ADDR_MASK  = 32'h0,
  parameter int unsigned MAX_WAIT   = 255,
  parameter int unsigned WAIT_W     = 8
) (
  input  logic        lpc_clock,
  input  logic        lpc_reset,
  input  logic [3:0]  lpc_ad,
  input  logic        lpc_frame,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_start,
  output logic [3:0]  out_cyctype_dir,
  output logic [31:0] out_addr,
  output logic [31:0] out_data,
  output logic [1:0]  out_data_size,
  output logic [3:0]  out_sync,
  output logic        out_timeout,
  output logic        out_abort,
  output logic        out_overflow
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_MSIZE, S_DATA,
    S_TAR1, S_TAR2, S_SYNC, S_TARE1, S_TARE2
  } state_t;

  localparam logic [WAIT_W-1:0] LP_MAX_WAIT = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] LP_WAIT_ONE = WAIT_W'(1);

  state_t             r_state, w_state_nxt;
  logic [3:0]         r_start, w_start_nxt;
  logic [3:0]         r_ctdir, w_ctdir_nxt;
  logic               r_fwh, w_fwh_nxt;
  logic               r_write, w_write_nxt;
  logic [31:0]        r_addr, w_addr_nxt;
  logic [31:0]        r_data, w_data_nxt;
  logic [1:0]         r_size, w_size_nxt;
  logic [3:0]         r_sync, w_sync_nxt;
  logic [3:0]         r_cnt, w_cnt_nxt;
  logic [2:0]         r_nib, w_nib_nxt;
  logic [WAIT_W-1:0]  r_wait, w_wait_nxt;
  logic [WAIT_W-1:0]  w_wait_inc;

  logic        w_start_ok, w_data_last, w_emit, w_timeout, w_abort;
  logic        w_pass, w_load, w_drop;

  logic        r_valid, r_abort, r_ovf, r_out_timeout;
  logic [3:0]  r_out_start, r_out_ctdir, r_out_sync;
  logic [31:0] r_out_addr, r_out_data;
  logic [1:0]  r_out_size;

  assign w_start_ok = ((lpc_ad == 4'b0000) && (ENABLE_IO || ENABLE_MEM)) ||
                      (((lpc_ad == 4'b1101) || (lpc_ad == 4'b1110)) && ENABLE_FWH);
  assign w_data_last = ({1'b0, r_nib} == ((4'd2 << r_size) - 4'd1));
  assign w_wait_inc  = r_wait + LP_WAIT_ONE;

  always_ff @(posedge lpc_clock or posedge lpc_reset) begin
    if (lpc_reset) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_nxt = r_start;
    w_ctdir_nxt = r_ctdir;
    w_fwh_nxt   = r_fwh;
    w_write_nxt = r_write;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_size_nxt  = r_size;
    w_sync_nxt  = r_sync;
    w_cnt_nxt   = r_cnt;
    w_nib_nxt   = r_nib;
    w_wait_nxt  = r_wait;
    w_emit      = 1'b0;
    w_timeout   = 1'b0;
    w_abort     = 1'b0;
    // LFRAME# low overrides whatever phase we were in: abort, restart or give up.
    if (!lpc_frame) begin
      if (lpc_ad == 4'b1111) begin
        w_state_nxt = S_IDLE;
        w_abort     = 1'b1;
      end else if (w_start_ok) begin
        w_state_nxt = S_START;
        w_start_nxt = lpc_ad;
      end else begin
        w_state_nxt = S_IDLE;
      end
    end else begin
      case (r_state)
        S_START: begin
          w_data_nxt = '0;
          w_size_nxt = 2'd0;
          w_sync_nxt = 4'd0;
          w_nib_nxt  = 3'd0;
          if (r_start == 4'b0000) begin
            w_fwh_nxt   = 1'b0;
            w_ctdir_nxt = lpc_ad;
            w_write_nxt = lpc_ad[1];
            w_addr_nxt  = '0;
            if ((lpc_ad[3:2] == 2'b00) && ENABLE_IO) begin
              w_cnt_nxt   = 4'd3;
              w_state_nxt = S_ADDR;
            end else if ((lpc_ad[3:2] == 2'b01) && ENABLE_MEM) begin
              w_cnt_nxt   = 4'd7;
              w_state_nxt = S_ADDR;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_fwh_nxt   = 1'b1;
            w_write_nxt = (r_start == 4'b1110);
            w_ctdir_nxt = {2'b00, (r_start == 4'b1110), 1'b0};
            w_addr_nxt  = {28'h0, lpc_ad};
            w_cnt_nxt   = 4'd6;
            w_state_nxt = S_ADDR;
          end
        end
        S_ADDR: begin
          w_addr_nxt = {r_addr[27:0], lpc_ad};
          w_cnt_nxt  = r_cnt - 4'd1;
          if (r_cnt == 4'd0) begin
            if (r_fwh)        w_state_nxt = S_MSIZE;
            else if (r_write) w_state_nxt = S_DATA;
            else              w_state_nxt = S_TAR1;
          end
        end
        S_MSIZE: begin
          if (lpc_ad[3:2] == 2'b00 && lpc_ad[1:0] != 2'b11) begin
            w_size_nxt  = lpc_ad[1:0];
            w_state_nxt = r_write ? S_DATA : S_TAR1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_DATA: begin
          w_data_nxt[{r_nib, 2'b00} +: 4] = lpc_ad;
          w_nib_nxt = r_nib + 3'd1;
          if (w_data_last) w_state_nxt = r_write ? S_TAR1 : S_TARE1;
        end
        S_TAR1: w_state_nxt = S_TAR2;
        S_TAR2: begin
          w_wait_nxt  = '0;
          w_state_nxt = S_SYNC;
        end
        S_SYNC: begin
          case (lpc_ad)
            4'b0101, 4'b0110: begin
              w_wait_nxt = w_wait_inc;
              if (w_wait_inc == LP_MAX_WAIT) begin
                w_emit      = 1'b1;
                w_timeout   = 1'b1;
                w_state_nxt = S_IDLE;
              end
            end
            4'b0000, 4'b1001, 4'b1010: begin
              w_sync_nxt  = lpc_ad;
              w_nib_nxt   = 3'd0;
              w_state_nxt = r_write ? S_TARE1 : S_DATA;
            end
            default: w_state_nxt = S_IDLE;
          endcase
        end
        S_TARE1: w_state_nxt = S_TARE2;
        S_TARE2: begin
          w_emit      = 1'b1;
          w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge lpc_clock or posedge lpc_reset) begin
    if (lpc_reset) begin
      r_start <= '0;
      r_ctdir <= '0;
      r_fwh   <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_size  <= '0;
      r_sync  <= '0;
      r_cnt   <= '0;
      r_nib   <= '0;
      r_wait  <= '0;
    end else begin
      r_start <= w_start_nxt;
      r_ctdir <= w_ctdir_nxt;
      r_fwh   <= w_fwh_nxt;
      r_write <= w_write_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_size  <= w_size_nxt;
      r_sync  <= w_sync_nxt;
      r_cnt   <= w_cnt_nxt;
      r_nib   <= w_nib_nxt;
      r_wait  <= w_wait_nxt;
    end
  end

  // Filtered-out records vanish silently; only a passing record can overflow.
  assign w_pass = ((r_addr & ADDR_MASK) == (ADDR_BASE & ADDR_MASK));
  assign w_load = w_emit && w_pass && (!r_valid || out_ready);
  assign w_drop = w_emit && w_pass && r_valid && !out_ready;

  always_ff @(posedge lpc_clock or posedge lpc_reset) begin
    if (lpc_reset) begin
      r_valid       <= 1'b0;
      r_abort       <= 1'b0;
      r_ovf         <= 1'b0;
      r_out_start   <= '0;
      r_out_ctdir   <= '0;
      r_out_addr    <= '0;
      r_out_data    <= '0;
      r_out_size    <= '0;
      r_out_sync    <= '0;
      r_out_timeout <= 1'b0;
    end else begin
      r_abort <= w_abort;
      if (w_drop) r_ovf <= 1'b1;
      if (w_load) begin
        r_valid       <= 1'b1;
        r_out_start   <= r_start;
        r_out_ctdir   <= r_ctdir;
        r_out_addr    <= r_addr;
        r_out_data    <= w_timeout ? 32'h0 : r_data;
        r_out_size    <= r_size;
        r_out_sync    <= w_timeout ? lpc_ad : r_sync;
        r_out_timeout <= w_timeout;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid       = r_valid;
  assign out_abort       = r_abort;
  assign out_overflow    = r_ovf;
  assign out_start       = r_out_start;
  assign out_cyctype_dir = r_out_ctdir;
  assign out_addr        = r_out_addr;
  assign out_data        = r_out_data;
  assign out_data_size   = r_out_size;
  assign out_sync        = r_out_sync;
  assign out_timeout     = r_out_timeout;

endmodule

// File: tb/tb_lpc_decoder_ext.sv
// Bench for lpc_decoder_ext: three instances (default, MAX_WAIT=4, address filter 0x80/0xFFFF)
// share one LPC bus; each has its own expected-record queue.
module tb_lpc_decoder_ext;

  typedef struct packed {
    logic [3:0]  start;
    logic [3:0]  ctdir;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [3:0]  sync;
    logic        timeout;
  } rec_t;

  typedef struct {
    int          kind;      // 0 I/O, 1 memory, 2 FWH
    bit          wr;
    logic [31:0] addr;
    logic [31:0] bus_data;
    logic [1:0]  msize;
    int          nwait;
    logic [3:0]  wait_nib;
    logic [3:0]  sync;
    logic [3:0]  e_start;
    logic [3:0]  e_ctdir;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic [1:0]  e_size;
  } vec_t;

  localparam int NV = 11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] lpc_ad = 4'hF;
  logic       lpc_frame = 1'b1;
  logic       out_ready = 1'b1;

  logic        o_valid[3], o_abort[3], o_overflow[3], o_timeout[3];
  logic [3:0]  o_start[3], o_ctdir[3], o_sync[3];
  logic [31:0] o_addr[3], o_data[3];
  logic [1:0]  o_size[3];

  int n_checks = 0;
  int n_errors = 0;
  rec_t q0[$], q1[$], q2[$];
  vec_t tbl[NV];

  always #15 clk = ~clk;

  lpc_decoder_ext u_dut0 (
    .lpc_clock(clk), .lpc_reset(rst), .lpc_ad(lpc_ad), .lpc_frame(lpc_frame),
    .out_valid(o_valid[0]), .out_ready(out_ready), .out_start(o_start[0]),
    .out_cyctype_dir(o_ctdir[0]), .out_addr(o_addr[0]), .out_data(o_data[0]),
    .out_data_size(o_size[0]), .out_sync(o_sync[0]), .out_timeout(o_timeout[0]),
    .out_abort(o_abort[0]), .out_overflow(o_overflow[0]));

  lpc_decoder_ext #(.MAX_WAIT(4)) u_dut1 (
    .lpc_clock(clk), .lpc_reset(rst), .lpc_ad(lpc_ad), .lpc_frame(lpc_frame),
    .out_valid(o_valid[1]), .out_ready(out_ready), .out_start(o_start[1]),
    .out_cyctype_dir(o_ctdir[1]), .out_addr(o_addr[1]), .out_data(o_data[1]),
    .out_data_size(o_size[1]), .out_sync(o_sync[1]), .out_timeout(o_timeout[1]),
    .out_abort(o_abort[1]), .out_overflow(o_overflow[1]));

  lpc_decoder_ext #(.ADDR_BASE(32'h80), .ADDR_MASK(32'hFFFF)) u_dut2 (
    .lpc_clock(clk), .lpc_reset(rst), .lpc_ad(lpc_ad), .lpc_frame(lpc_frame),
    .out_valid(o_valid[2]), .out_ready(out_ready), .out_start(o_start[2]),
    .out_cyctype_dir(o_ctdir[2]), .out_addr(o_addr[2]), .out_data(o_data[2]),
    .out_data_size(o_size[2]), .out_sync(o_sync[2]), .out_timeout(o_timeout[2]),
    .out_abort(o_abort[2]), .out_overflow(o_overflow[2]));

  function automatic rec_t get_rec(input int i);
    return {o_start[i], o_ctdir[i], o_addr[i], o_data[i], o_size[i], o_sync[i], o_timeout[i]};
  endfunction

  function automatic vec_t mk(input int kind, input bit wr, input logic [31:0] addr,
                              input logic [31:0] bd, input logic [1:0] ms, input int nw,
                              input logic [3:0] wn, input logic [3:0] sy, input logic [3:0] es,
                              input logic [3:0] ec, input logic [31:0] ea, input logic [31:0] ed,
                              input logic [1:0] esz);
    vec_t v;
    v.kind = kind; v.wr = wr; v.addr = addr; v.bus_data = bd; v.msize = ms;
    v.nwait = nw; v.wait_nib = wn; v.sync = sy;
    v.e_start = es; v.e_ctdir = ec; v.e_addr = ea; v.e_data = ed; v.e_size = esz;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic check_zero(input int i);
    n_checks++;
    if ({o_valid[i], o_abort[i], o_overflow[i], get_rec(i)} !== '0) begin
      n_errors++;
      $display("FAIL reset_dut%0d: got valid=%b abort=%b ovf=%b addr=%h data=%h, required all 0",
               i, o_valid[i], o_abort[i], o_overflow[i], o_addr[i], o_data[i]);
    end
  endtask

  task automatic check_pop(input int i);
    rec_t got, exp;
    bit   empty;
    got = get_rec(i);
    n_checks++;
    case (i)
      0:       empty = (q0.size() == 0);
      1:       empty = (q1.size() == 0);
      default: empty = (q2.size() == 0);
    endcase
    if (empty) begin
      n_errors++;
      $display("FAIL record_dut%0d: got unexpected addr=%h data=%h, required no record", i, got.addr, got.data);
    end else begin
      case (i)
        0:       exp = q0.pop_front();
        1:       exp = q1.pop_front();
        default: exp = q2.pop_front();
      endcase
      if (got !== exp) begin
        n_errors++;
        $display("FAIL record_dut%0d: got st=%h ct=%h a=%h d=%h sz=%0d sy=%h to=%b, required st=%h ct=%h a=%h d=%h sz=%0d sy=%h to=%b",
                 i, got.start, got.ctdir, got.addr, got.data, got.size, got.sync, got.timeout,
                 exp.start, exp.ctdir, exp.addr, exp.data, exp.size, exp.sync, exp.timeout);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_ready) begin
      for (int i = 0; i < 3; i++) if (o_valid[i]) check_pop(i);
    end
  end

  task automatic expect_vec(input vec_t v);
    rec_t r, r1;
    r.start = v.e_start; r.ctdir = v.e_ctdir; r.addr = v.e_addr; r.data = v.e_data;
    r.size = v.e_size; r.sync = v.sync; r.timeout = 1'b0;
    q0.push_back(r);
    r1 = r;
    if (v.nwait >= 4) begin
      r1.data = 32'h0; r1.sync = v.wait_nib; r1.timeout = 1'b1;
    end
    q1.push_back(r1);
    if ((v.e_addr & 32'hFFFF) == 32'h80) q2.push_back(r);
  endtask

  task automatic nib(input logic f, input logic [3:0] a);
    @(posedge clk);
    #1;
    lpc_frame = f;
    lpc_ad    = a;
  endtask

  task automatic drive_cycle(input vec_t v);
    int nd;
    nib(1'b0, (v.kind == 2) ? (v.wr ? 4'hE : 4'hD) : 4'h0);
    if (v.kind == 2) begin
      nib(1'b1, v.addr[31:28]);
      for (int k = 6; k >= 0; k--) nib(1'b1, v.addr[4*k +: 4]);
      nib(1'b1, {2'b00, v.msize});
      nd = 2 << v.msize;
    end else begin
      nib(1'b1, {1'b0, (v.kind == 1), v.wr, 1'b0});
      for (int k = (v.kind == 1) ? 7 : 3; k >= 0; k--) nib(1'b1, v.addr[4*k +: 4]);
      nd = 2;
    end
    if (v.wr) for (int k = 0; k < nd; k++) nib(1'b1, v.bus_data[4*k +: 4]);
    nib(1'b1, 4'hF);
    nib(1'b1, 4'hF);
    for (int w = 0; w < v.nwait; w++) nib(1'b1, v.wait_nib);
    nib(1'b1, v.sync);
    if (!v.wr) for (int k = 0; k < nd; k++) nib(1'b1, v.bus_data[4*k +: 4]);
    nib(1'b1, 4'hF);
    nib(1'b1, 4'hF);
    nib(1'b1, 4'hF);
  endtask

  task automatic drain();
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(0, 1'b1, 32'h00000080, 32'h000000A5, 2'd0, 0,  4'h6, 4'h0, 4'h0, 4'h2, 32'h00000080, 32'h000000A5, 2'd0);
    tbl[1]  = mk(1, 1'b0, 32'hFFFFFFF0, 32'h000000C3, 2'd0, 3,  4'h6, 4'h0, 4'h0, 4'h4, 32'hFFFFFFF0, 32'h000000C3, 2'd0);
    tbl[2]  = mk(2, 1'b0, 32'h0FFFFFF0, 32'h87654321, 2'd2, 0,  4'h6, 4'h0, 4'hD, 4'h0, 32'h0FFFFFF0, 32'h87654321, 2'd2);
    tbl[3]  = mk(0, 1'b1, 32'h0000002E, 32'h00000011, 2'd0, 0,  4'h6, 4'h0, 4'h0, 4'h2, 32'h0000002E, 32'h00000011, 2'd0);
    tbl[4]  = mk(0, 1'b0, 32'h00000080, 32'h0000005A, 2'd0, 1,  4'h5, 4'hA, 4'h0, 4'h0, 32'h00000080, 32'h0000005A, 2'd0);
    tbl[5]  = mk(1, 1'b1, 32'h12340080, 32'h0000007E, 2'd0, 0,  4'h6, 4'h9, 4'h0, 4'h6, 32'h12340080, 32'h0000007E, 2'd0);
    tbl[6]  = mk(2, 1'b1, 32'h3ABCD080, 32'h0000BEEF, 2'd1, 2,  4'h6, 4'h0, 4'hE, 4'h2, 32'h3ABCD080, 32'h0000BEEF, 2'd1);
    tbl[7]  = mk(1, 1'b0, 32'h00000080, 32'h00000099, 2'd0, 5,  4'h5, 4'h0, 4'h0, 4'h4, 32'h00000080, 32'h00000099, 2'd0);
    tbl[8]  = mk(0, 1'b0, 32'h00000080, 32'h0000003C, 2'd0, 4,  4'h6, 4'h0, 4'h0, 4'h0, 32'h00000080, 32'h0000003C, 2'd0);
    tbl[9]  = mk(0, 1'b0, 32'h00000080, 32'h00000042, 2'd0, 3,  4'h6, 4'h9, 4'h0, 4'h0, 32'h00000080, 32'h00000042, 2'd0);
    tbl[10] = mk(1, 1'b0, 32'hFFFF0080, 32'h00000001, 2'd0, 20, 4'h6, 4'h0, 4'h0, 4'h4, 32'hFFFF0080, 32'h00000001, 2'd0);

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check_zero(i);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      expect_vec(tbl[i]);
      drive_cycle(tbl[i]);
    end
    drain();

    // Partial I/O cycle interrupted by a fresh START in the address phase.
    nib(1'b0, 4'h0); nib(1'b1, 4'h2); nib(1'b1, 4'h0); nib(1'b1, 4'h0);
    expect_vec(tbl[0]);
    drive_cycle(tbl[0]);
    drain();

    // Master abort inside the address phase.
    nib(1'b0, 4'h0); nib(1'b1, 4'h2); nib(1'b1, 4'h0); nib(1'b0, 4'hF); nib(1'b1, 4'hF);
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("abort_pulse_dut%0d", i), 64'(o_abort[i]), 64'd1);
    nib(1'b1, 4'hF);
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("abort_clear_dut%0d", i), 64'(o_abort[i]), 64'd0);
    drain();

    // Consumer stalled across two completed writes.
    out_ready = 1'b0;
    expect_vec(tbl[0]);
    drive_cycle(tbl[0]);
    drive_cycle(tbl[3]);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("held_valid_dut%0d", i), 64'(o_valid[i]), 64'd1);
    chk("held_addr_dut0", 64'(o_addr[0]), 64'h80);
    chk("held_data_dut0", 64'(o_data[0]), 64'hA5);
    chk("overflow_dut0", 64'(o_overflow[0]), 64'd1);
    chk("overflow_dut1", 64'(o_overflow[1]), 64'd1);
    chk("overflow_filtered_dut2", 64'(o_overflow[2]), 64'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Reset mid-cycle with a record pending and overflow still set.
    out_ready = 1'b0;
    drive_cycle(tbl[5]);
    nib(1'b0, 4'h0); nib(1'b1, 4'h6); nib(1'b1, 4'h1);
    rst = 1'b1;
    #2;
    for (int i = 0; i < 3; i++) check_zero(i);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    nib(1'b1, 4'hF);
    expect_vec(tbl[1]);
    drive_cycle(tbl[1]);
    drain();

    chk("queue_left_dut0", 64'(q0.size()), 64'd0);
    chk("queue_left_dut1", 64'(q1.size()), 64'd0);
    chk("queue_left_dut2", 64'(q2.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
